// File: rtl/vc_input_buffer_pkg.sv
// vc_input_buffer_pkg: flit-type and per-VC state encodings shared by the VC input buffer.
// Contents: flit_type_e (2-bit type field at the top of every flit), vc_state_e
// (per-VC allocation state) and is_head(), true for the types that open a packet.
package vc_input_buffer_pkg;

    typedef enum logic [1:0] {
        FT_BODY = 2'b00,
        FT_HEAD = 2'b01,
        FT_TAIL = 2'b10,
        FT_HT   = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_REQ    = 2'b01,
        ST_ACTIVE = 2'b10
    } vc_state_e;

    function automatic logic is_head(flit_type_e t);
        return t == FT_HEAD || t == FT_HT;
    endfunction

endpackage

// File: rtl/vc_input_buffer_fifo.sv
// vc_fifo: single-VC flit FIFO with a combinational front-of-queue output.
// Ports: clk, clr_n (async active-low reset), push_i/pop_i (qualified by the caller:
// push_i never arrives on full without pop_i, pop_i never arrives on empty),
// data_i (flit to store), data_o (front flit), full_o, empty_o.
module vc_fifo #(
    parameter int FLIT_W = 16,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [FLIT_W-1:0] data_i,
    output logic [FLIT_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    count_q;

    // Storage carries no reset: contents are meaningless while count_q is zero.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{PTR_W{1'b0}}, push_i} - {{PTR_W{1'b0}}, pop_i};
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    // count reaches DEPTH exactly when its top bit sets.
    assign full_o  = count_q[PTR_W];
    assign empty_o = count_q == '0;

endmodule

// File: rtl/vc_input_buffer.sv
// vc_input_buffer: router input port holding one flit FIFO per virtual channel.
// Ports: clk, clr_n (async active-low reset); in_valid/in_vc/in_flit write side;
// rd_en/rd_vc pop/peek select; out_flit/out_valid front of FIFO rd_vc;
// vc_req/vc_active per-VC allocation state; vc_empty per-VC empty;
// credit_out per-VC one-cycle credit after each pop; err sticky protocol error.
module vc_input_buffer
    import vc_input_buffer_pkg::*;
#(
    parameter int FLIT_W = 16,
    parameter int NUM_VC = 2,
    parameter int VC_W   = 1,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              in_valid,
    input  logic [VC_W-1:0]   in_vc,
    input  logic [FLIT_W-1:0] in_flit,
    input  logic              rd_en,
    input  logic [VC_W-1:0]   rd_vc,
    output logic [FLIT_W-1:0] out_flit,
    output logic              out_valid,
    output logic [NUM_VC-1:0] vc_req,
    output logic [NUM_VC-1:0] vc_active,
    output logic [NUM_VC-1:0] vc_empty,
    output logic [NUM_VC-1:0] credit_out,
    output logic              err
);

    logic [NUM_VC-1:0] in_sel, rd_sel, push, pop, full, empty;
    logic [FLIT_W-1:0] front [NUM_VC];
    flit_type_e        ft [NUM_VC];
    vc_state_e         state_q [NUM_VC];
    logic [NUM_VC-1:0] credit_q;
    logic              err_q, err_set;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        assign in_sel[v] = in_vc == VC_W'(v);
        assign rd_sel[v] = rd_vc == VC_W'(v);
        // Popping an empty FIFO is a no-op; a same-cycle pop makes room on a full one.
        assign pop[v]    = rd_en && rd_sel[v] && !empty[v];
        assign push[v]   = in_valid && in_sel[v] && (!full[v] || pop[v]);
        assign ft[v]     = flit_type_e'(front[v][FLIT_W-1 -: 2]);
        assign vc_req[v]    = state_q[v] == ST_REQ;
        assign vc_active[v] = state_q[v] == ST_ACTIVE;
        vc_fifo #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
            .clk    (clk),
            .clr_n  (clr_n),
            .push_i (push[v]),
            .pop_i  (pop[v]),
            .data_i (in_flit),
            .data_o (front[v]),
            .full_o (full[v]),
            .empty_o(empty[v])
        );
    end

    always_comb begin
        out_flit  = front[0];
        out_valid = 1'b0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (rd_sel[i]) begin
                out_flit  = front[i];
                out_valid = !empty[i];
            end
        end
    end

    // Error sources: out-of-range VC index, overflow, and a front flit whose type
    // does not fit the VC state (body/tail with no packet open, head inside a packet).
    always_comb begin
        err_set = (in_valid && !(|in_sel)) || (rd_en && !(|rd_sel));
        for (int i = 0; i < NUM_VC; i++) begin
            err_set |= in_valid && in_sel[i] && full[i] && !pop[i];
            err_set |= !empty[i] && (state_q[i] == ST_IDLE ? !is_head(ft[i]) :
                                     state_q[i] == ST_ACTIVE && is_head(ft[i]));
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < NUM_VC; i++) state_q[i] <= ST_IDLE;
            credit_q <= '0;
            err_q    <= 1'b0;
        end else begin
            credit_q <= pop;
            if (err_set) err_q <= 1'b1;
            for (int i = 0; i < NUM_VC; i++) begin
                case (state_q[i])
                    ST_IDLE:   if (!empty[i] && is_head(ft[i])) state_q[i] <= ST_REQ;
                    ST_REQ:    if (pop[i]) state_q[i] <= ft[i] == FT_HEAD ? ST_ACTIVE : ST_IDLE;
                    ST_ACTIVE: if (pop[i] && ft[i] == FT_TAIL) state_q[i] <= ST_IDLE;
                    default:   state_q[i] <= ST_IDLE;
                endcase
            end
        end
    end

    assign vc_empty   = empty;
    assign credit_out = credit_q;
    assign err        = err_q;

endmodule

// File: tb/tb_vc_input_buffer.sv
// tb_vc_input_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_vc_input_buffer;

    logic        clk = 1'b0, clr_n = 1'b0;
    logic        in_valid = 1'b0, rd_en = 1'b0;
    logic [0:0]  in_vc = '0, rd_vc = '0;
    logic [15:0] in_flit = '0, out_flit;
    logic        out_valid, err;
    logic [1:0]  vc_req, vc_active, vc_empty, credit_out;

    vc_input_buffer dut (
        .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in_vc(in_vc), .in_flit(in_flit),
        .rd_en(rd_en), .rd_vc(rd_vc), .out_flit(out_flit), .out_valid(out_valid),
        .vc_req(vc_req), .vc_active(vc_active), .vc_empty(vc_empty),
        .credit_out(credit_out), .err(err)
    );

    always #5 clk = ~clk;

    localparam int IDLE = 0, REQ = 1, ACT = 2;

    int          total = 0, bad = 0;
    logic [15:0] q [2][$];
    int          st [2];
    logic [1:0]  exp_cr;
    logic        exp_err;
    logic        in_pkt [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic verify();
        logic [1:0] e_empty, e_req, e_act;
        for (int v = 0; v < 2; v++) begin
            e_empty[v] = q[v].size() == 0;
            e_req[v]   = st[v] == REQ;
            e_act[v]   = st[v] == ACT;
        end
        check("vc_empty", 32'(vc_empty), 32'(e_empty));
        check("vc_req", 32'(vc_req), 32'(e_req));
        check("vc_active", 32'(vc_active), 32'(e_act));
        check("credit_out", 32'(credit_out), 32'(exp_cr));
        check("err", 32'(err), 32'(exp_err));
        check("out_valid", 32'(out_valid), 32'(q[rd_vc].size() != 0));
        if (q[rd_vc].size() != 0) check("out_flit", 32'(out_flit), 32'(q[rd_vc][0]));
    endtask

    task automatic model_clear();
        for (int v = 0; v < 2; v++) begin
            q[v].delete();
            st[v] = IDLE;
            in_pkt[v] = 1'b0;
        end
        exp_cr = '0;
        exp_err = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rd_en = 1'b0;
        clr_n = 1'b0;
        model_clear();
        #2;
        verify();
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        verify();
    endtask

    // One clock: drive inputs, advance the model by the packet/credit rules, compare after the edge.
    task automatic step(input logic iv, input logic ivc, input logic [15:0] f,
                        input logic re, input logic rv);
        int pv;
        logic [1:0] t;
        logic hd;
        in_valid = iv;
        in_vc = ivc;
        in_flit = f;
        rd_en = re;
        rd_vc = rv;
        pv = (re && q[rv].size() != 0) ? int'(rv) : -1;
        exp_cr = '0;
        if (pv >= 0) exp_cr[pv] = 1'b1;
        for (int v = 0; v < 2; v++) begin
            if (q[v].size() != 0) begin
                t = q[v][0][15:14];
                hd = t == 2'b01 || t == 2'b11;
                if (st[v] == IDLE) begin
                    if (hd) st[v] = REQ;
                    else exp_err = 1'b1;
                end else if (st[v] == REQ) begin
                    if (pv == v) st[v] = (t == 2'b01) ? ACT : IDLE;
                end else begin
                    if (hd) exp_err = 1'b1;
                    if (pv == v && t == 2'b10) st[v] = IDLE;
                end
            end
        end
        if (pv >= 0) void'(q[pv].pop_front());
        if (iv) begin
            if (q[ivc].size() < 4) q[ivc].push_back(f);
            else exp_err = 1'b1;
        end
        @(posedge clk);
        #1;
        verify();
    endtask

    task automatic idle(input logic rv);
        step(1'b0, 1'b0, 16'h0, 1'b0, rv);
    endtask

    initial begin
        logic [15:0] f;
        logic ivc, rv, iv, re;
        model_clear();
        #1;
        // Reset mid-stream with data queued
        do_reset();
        step(1'b1, 1'b0, 16'h4011, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h0012, 1'b0, 1'b0);
        in_valid = 1'b0;
        clr_n = 1'b0;
        #2;
        check("rst_empty", 32'(vc_empty), 32'h3);
        check("rst_req", 32'(vc_req), 32'h0);
        check("rst_credit", 32'(credit_out), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        do_reset();

        // Single packet on VC0
        step(1'b1, 1'b0, 16'h4001, 1'b0, 1'b0);
        check("p_req_early", 32'(vc_req[0]), 32'h0);
        step(1'b1, 1'b0, 16'h0002, 1'b0, 1'b0);
        check("p_req", 32'(vc_req[0]), 32'h1);
        step(1'b1, 1'b0, 16'h8003, 1'b0, 1'b0);
        check("p_peek", 32'(out_flit), 32'h4001);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        check("p_active", 32'(vc_active[0]), 32'h1);
        check("p_cr1", 32'(credit_out), 32'h1);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        check("p_cr2", 32'(credit_out), 32'h1);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        check("p_cr3", 32'(credit_out), 32'h1);
        check("p_idle", 32'({vc_req[0], vc_active[0]}), 32'h0);
        idle(1'b0);
        check("p_cr_end", 32'(credit_out), 32'h0);

        // Full FIFO with simultaneous write+pop, then overflow
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 16'hC000 | 16'(i), 1'b0, 1'b1);
        check("full_empty", 32'(vc_empty[1]), 32'h0);
        step(1'b1, 1'b1, 16'hC005, 1'b1, 1'b1);
        check("full_wp_err", 32'(err), 32'h0);
        step(1'b1, 1'b1, 16'hC006, 1'b0, 1'b1);
        check("full_ovf_err", 32'(err), 32'h1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        check("full_drained", 32'(vc_empty[1]), 32'h1);

        // Interleaved single-flit packets
        do_reset();
        step(1'b1, 1'b0, 16'hC0AA, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'hC0BB, 1'b0, 1'b0);
        idle(1'b0);
        check("il_req", 32'(vc_req), 32'h3);
        check("il_out0", 32'(out_flit), 32'hC0AA);
        idle(1'b1);
        check("il_out1", 32'(out_flit), 32'hC0BB);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        check("il_idle", 32'({vc_req, vc_active}), 32'h0);

        // Protocol errors
        do_reset();
        step(1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
        idle(1'b0);
        check("e_body_err", 32'(err), 32'h1);
        check("e_body_st", 32'({vc_req[0], vc_active[0]}), 32'h0);
        do_reset();
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        check("e_rd_credit", 32'(credit_out), 32'h0);
        check("e_rd_err", 32'(err), 32'h0);

        // Pointer wrap: 10 flits through VC0
        do_reset();
        for (int i = 0; i < 10; i++) begin
            f = (i == 0) ? 16'h4100 : (i == 9) ? 16'h8109 : 16'h0100 | 16'(i);
            step(1'b1, 1'b0, f, i >= 2, 1'b0);
        end
        while (q[0].size() != 0) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        check("wrap_err", 32'(err), 32'h0);

        // Random well-formed traffic: no error may appear
        do_reset();
        for (int n = 0; n < 400; n++) begin
            ivc = 1'($urandom_range(1));
            rv = 1'($urandom_range(1));
            iv = $urandom_range(2) != 0 && q[ivc].size() < 4;
            f = 16'($urandom);
            if (!in_pkt[ivc]) f[15:14] = $urandom_range(1) ? 2'b01 : 2'b11;
            else f[15:14] = $urandom_range(3) != 0 ? 2'b00 : 2'b10;
            if (iv) in_pkt[ivc] = f[15:14] == 2'b01 || (in_pkt[ivc] && f[15:14] == 2'b00);
            re = $urandom_range(2) != 0 && st[rv] != IDLE;
            step(iv, ivc, f, re, rv);
        end
        check("rand_ok_err", 32'(err), 32'h0);

        // Random unconstrained traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(60) == 0) do_reset();
            step(1'($urandom_range(1)), 1'($urandom_range(1)), 16'($urandom),
                 1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
